tusca_tx_relatorio: RTL

//  UART transmitter (8N1, LSB first) that sends the TUSCA status report back to the host.
//  It is the transmit side of the serial link whose receivers are rx_serial_medida and rx_serial_config.
//  On an enviar pulse it snapshots the temperature, humidity and level values, then serializes a 7-byte frame.
//  It sits in tusca_fd; the new FSM state RELATA in tusca_uc drives it after each measurement.

---
 rtl/tusca_tx_relatorio_pkg.sv | 24 ++
 rtl/tusca_tx_relatorio_serial.sv | 97 +++++++++
 rtl/tusca_tx_relatorio.sv | 128 ++++++++++++
 3 files changed

// File: rtl/tusca_tx_relatorio_pkg.sv
// Shared definitions for the TUSCA status-report transmitter.
// Optional feature macro: TUSCA_TX_PARIDADE_EN (even parity bit per byte).
package tusca_tx_relatorio_pkg;

  typedef enum logic [2:0] {
    OCIOSO  = 3'd0,
    CARREGA = 3'd1,
    ENVIA   = 3'd2,
    PROXIMO = 3'd3,
    FIM     = 3'd4
  } estado_t;

  localparam logic [7:0]  FRAME_HDR = 8'h23;
  localparam int unsigned FRAME_LEN = 7;
  localparam int unsigned IDX_W     = 3;

  // Checksum byte: XOR of header and the five payload bytes.
  function automatic logic [7:0] soma_verif(input logic [15:0] temp,
                                            input logic [15:0] umid,
                                            input logic [1:0]  niv);
    return FRAME_HDR ^ temp[15:8] ^ temp[7:0] ^ umid[15:8] ^ umid[7:0] ^ {6'b0, niv};
  endfunction

endpackage

// File: rtl/tusca_tx_relatorio_serial.sv
// One-byte UART serializer: start, d0..d7, optional even parity, stop.
// Optional feature macro: TUSCA_TX_PARIDADE_EN.
module tx_serial_byte #(
  parameter int unsigned CLKS_POR_BIT = 434
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       partida,
  input  logic [7:0] dado,
  output logic       saida,
  output logic       fim
);

`ifdef TUSCA_TX_PARIDADE_EN
  localparam logic [3:0] BIT_ULT = 4'd10;
`else
  localparam logic [3:0] BIT_ULT = 4'd9;
`endif
  localparam int unsigned       BAUD_W   = (CLKS_POR_BIT > 1) ? $clog2(CLKS_POR_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_ULT = BAUD_W'(CLKS_POR_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_PEN = BAUD_W'(CLKS_POR_BIT - 2);

  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [3:0]        bit_q, bit_d;
  logic [7:0]        dado_q, dado_d;
  logic              saida_q, saida_d;
  logic              ativo_q, ativo_d;
  logic [3:0]        bit_prox;

  function automatic logic valor_bit(input logic [3:0] idx, input logic [7:0] b);
    if (idx == 4'd0) return 1'b0;
    if (idx <= 4'd8) return b[3'(idx - 4'd1)];
`ifdef TUSCA_TX_PARIDADE_EN
    if (idx == 4'd9) return ^b;
`endif
    return 1'b1;
  endfunction

  // Baud/bit counting; a partida seen in the last stop cycle reloads with no idle gap.
  always_comb begin
    baud_d   = baud_q;
    bit_d    = bit_q;
    dado_d   = dado_q;
    saida_d  = saida_q;
    ativo_d  = ativo_q;
    bit_prox = bit_q + 4'd1;
    if (ativo_q) begin
      if (baud_q == BAUD_ULT) begin
        baud_d = '0;
        if (bit_q == BIT_ULT) begin
          if (partida) begin
            dado_d  = dado;
            bit_d   = '0;
            saida_d = 1'b0;
          end else begin
            ativo_d = 1'b0;
            saida_d = 1'b1;
          end
        end else begin
          bit_d   = bit_prox;
          saida_d = valor_bit(bit_prox, dado_q);
        end
      end else begin
        baud_d = baud_q + 1'b1;
      end
    end else if (partida) begin
      ativo_d = 1'b1;
      dado_d  = dado;
      bit_d   = '0;
      baud_d  = '0;
      saida_d = 1'b0;
    end
  end

  // Serializer state registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      baud_q  <= '0;
      bit_q   <= '0;
      dado_q  <= '0;
      saida_q <= 1'b1;
      ativo_q <= 1'b0;
    end else begin
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      dado_q  <= dado_d;
      saida_q <= saida_d;
      ativo_q <= ativo_d;
    end
  end

  assign saida = saida_q;
  // Raised in the second-to-last stop cycle: the frame FSM needs two edges
  // (ENVIA->PROXIMO->ENVIA) to present the next byte exactly at stop end.
  assign fim = ativo_q && (bit_q == BIT_ULT) && (baud_q == BAUD_PEN);

endmodule

// File: rtl/tusca_tx_relatorio.sv
// TUSCA status-report transmitter: snapshots the inputs on enviar and sends
// the 7-byte frame 23,tH,tL,uH,uL,nivel,xor. Optional macro: TUSCA_TX_PARIDADE_EN.
import tusca_tx_relatorio_pkg::*;

module tusca_tx_relatorio #(
  parameter int unsigned CLKS_POR_BIT = 434
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enviar,
  input  logic [15:0] temperatura,
  input  logic [15:0] umidade,
  input  logic [1:0]  nivel,
  output logic        saida_serial,
  output logic        ocupado,
  output logic        pronto,
  output logic [2:0]  db_estado
);

  localparam logic [IDX_W-1:0] IDX_ULT = IDX_W'(FRAME_LEN - 1);
  localparam logic [IDX_W-1:0] IDX_FIM = IDX_W'(FRAME_LEN);

  estado_t          estado_q, estado_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [15:0]      temp_q, temp_d;
  logic [15:0]      umid_q, umid_d;
  logic [1:0]       nivel_q, nivel_d;
  logic [7:0]       chk_q, chk_d;
  logic             partida_q, partida_d;
  logic             ocupado_q, ocupado_d;
  logic             pronto_q, pronto_d;
  logic [7:0]       byte_atual;
  logic             fim_byte;

  // Byte selected for the serializer from the snapshot.
  always_comb begin
    byte_atual = FRAME_HDR;
    case (idx_q)
      3'd1:    byte_atual = temp_q[15:8];
      3'd2:    byte_atual = temp_q[7:0];
      3'd3:    byte_atual = umid_q[15:8];
      3'd4:    byte_atual = umid_q[7:0];
      3'd5:    byte_atual = {6'b0, nivel_q};
      3'd6:    byte_atual = chk_q;
      default: byte_atual = FRAME_HDR;
    endcase
  end

  // Frame FSM next state; partida is issued one cycle ahead of the reload edge.
  always_comb begin
    estado_d  = estado_q;
    idx_d     = idx_q;
    temp_d    = temp_q;
    umid_d    = umid_q;
    nivel_d   = nivel_q;
    chk_d     = chk_q;
    partida_d = 1'b0;
    case (estado_q)
      OCIOSO: begin
        if (enviar) begin
          temp_d   = temperatura;
          umid_d   = umidade;
          nivel_d  = nivel;
          estado_d = CARREGA;
        end
      end
      CARREGA: begin
        chk_d     = soma_verif(temp_q, umid_q, nivel_q);
        idx_d     = '0;
        partida_d = 1'b1;
        estado_d  = ENVIA;
      end
      ENVIA: begin
        if (fim_byte) begin
          idx_d     = idx_q + 1'b1;
          partida_d = (idx_q != IDX_ULT);
          estado_d  = PROXIMO;
        end
      end
      PROXIMO: estado_d = (idx_q < IDX_FIM) ? ENVIA : FIM;
      FIM:     estado_d = OCIOSO;
      default: estado_d = OCIOSO;
    endcase
    ocupado_d = (estado_d == CARREGA) || (estado_d == ENVIA) || (estado_d == PROXIMO);
    pronto_d  = (estado_d == FIM);
  end

  // FSM, snapshot and registered status outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q  <= OCIOSO;
      idx_q     <= '0;
      temp_q    <= '0;
      umid_q    <= '0;
      nivel_q   <= '0;
      chk_q     <= '0;
      partida_q <= 1'b0;
      ocupado_q <= 1'b0;
      pronto_q  <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      idx_q     <= idx_d;
      temp_q    <= temp_d;
      umid_q    <= umid_d;
      nivel_q   <= nivel_d;
      chk_q     <= chk_d;
      partida_q <= partida_d;
      ocupado_q <= ocupado_d;
      pronto_q  <= pronto_d;
    end
  end

  tx_serial_byte #(
    .CLKS_POR_BIT(CLKS_POR_BIT)
  ) u_serial (
    .clock  (clock),
    .reset  (reset),
    .partida(partida_q),
    .dado   (byte_atual),
    .saida  (saida_serial),
    .fim    (fim_byte)
  );

  assign ocupado   = ocupado_q;
  assign pronto    = pronto_q;
  assign db_estado = estado_q;

endmodule
